// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI far-end model of the gain preamp and dual-channel serial ADC.
`timescale 1ns/1ps
module adc_spi_responder #(
   parameter int         DATA_W      = 14,
   parameter int         PAD_BITS    = 2,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] GAIN_RESET  = 8'h11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   input  logic              amp_cs,
   input  logic              ad_conv,
   input  logic [DATA_W-1:0] sample_a,
   input  logic [DATA_W-1:0] sample_b,
   output logic              spi_miso,
   output logic              amp_dout,
   output logic [3:0]        gain_a,
   output logic [3:0]        gain_b,
   output logic              gain_valid,
   output logic              gain_err,
   output logic              busy,
   output logic              frame_done,
   output logic              conv_overrun
);
   localparam int FRAME = 3*PAD_BITS + 2*DATA_W;
   localparam int CNT_W = $clog2(FRAME);
   typedef enum logic {IDLE, SHIFT} state_t;
   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] sync_d [SYNC_STAGES];
   logic [3:0] dly_q, dly_d, cur;
   logic sck_rise, sck_fall, cs_rise, cs_fall, conv_rise;
   logic [7:0] gain_q, gain_d, gshift_q, gshift_d, dshift_q, dshift_d;
   logic [3:0] gcnt_q, gcnt_d;
   logic cs_act_q, cs_act_d, gain_valid_q, gain_valid_d, gain_err_q, gain_err_d;
   state_t state_q, state_d;
   logic [FRAME-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic frame_done_q, frame_done_d, conv_overrun_q, conv_overrun_d, last;
   // bit order in the synchronizer: {ad_conv, amp_cs, spi_mosi, spi_sck}
   always_comb begin
      sync_d[0] = {ad_conv, amp_cs, spi_mosi, spi_sck};
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      cur   = sync_q[SYNC_STAGES-1];
      dly_d = cur;
   end
   assign sck_rise  =  cur[0] & ~dly_q[0];
   assign sck_fall  = ~cur[0] &  dly_q[0];
   assign cs_rise   =  cur[2] & ~dly_q[2];
   assign cs_fall   = ~cur[2] &  dly_q[2];
   assign conv_rise =  cur[3] & ~dly_q[3];
   // cs_act qualifies cs_rise so the synchronizer filling with an idle-high cs after reset is not a transfer
   always_comb begin
      gain_d       = gain_q;
      gshift_d     = gshift_q;
      dshift_d     = dshift_q;
      gcnt_d       = gcnt_q;
      cs_act_d     = cs_act_q;
      gain_valid_d = 1'b0;
      gain_err_d   = 1'b0;
      if (cs_fall) begin
         cs_act_d = 1'b1;
         gcnt_d   = '0;
         dshift_d = gain_q;
      end else if (cs_rise) begin
         cs_act_d     = 1'b0;
         gain_valid_d = cs_act_q && gcnt_q == 4'd8;
         gain_err_d   = cs_act_q && gcnt_q != 4'd8;
         gain_d       = (cs_act_q && gcnt_q == 4'd8) ? gshift_q : gain_q;
      end else if (cs_act_q) begin
         if (sck_rise) begin
            gshift_d = {gshift_q[6:0], cur[1]};
            gcnt_d   = (gcnt_q == 4'hf) ? gcnt_q : gcnt_q + 4'd1;
         end
         if (sck_fall) dshift_d = {dshift_q[6:0], 1'b0};
      end
   end
   always_comb begin
      state_d        = state_q;
      sr_d           = sr_q;
      bit_cnt_d      = bit_cnt_q;
      last           = state_q == SHIFT && sck_fall && bit_cnt_q == CNT_W'(FRAME-1);
      frame_done_d   = last;
      conv_overrun_d = conv_rise && state_q == SHIFT && !last;
      if (conv_rise) begin
         state_d   = SHIFT;
         bit_cnt_d = '0;
         sr_d      = {{PAD_BITS{1'b0}}, sample_a, {PAD_BITS{1'b0}}, sample_b, {PAD_BITS{1'b0}}};
      end else if (last) begin
         state_d = IDLE;
      end else if (state_q == SHIFT && sck_fall) begin
         bit_cnt_d = bit_cnt_q + CNT_W'(1);
         sr_d      = {sr_q[FRAME-2:0], 1'b0};
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         dly_q          <= '0;
         gain_q         <= GAIN_RESET;
         gshift_q       <= '0;
         dshift_q       <= '0;
         gcnt_q         <= '0;
         cs_act_q       <= 1'b0;
         gain_valid_q   <= 1'b0;
         gain_err_q     <= 1'b0;
         state_q        <= IDLE;
         sr_q           <= '0;
         bit_cnt_q      <= '0;
         frame_done_q   <= 1'b0;
         conv_overrun_q <= 1'b0;
      end else begin
         sync_q         <= sync_d;
         dly_q          <= dly_d;
         gain_q         <= gain_d;
         gshift_q       <= gshift_d;
         dshift_q       <= dshift_d;
         gcnt_q         <= gcnt_d;
         cs_act_q       <= cs_act_d;
         gain_valid_q   <= gain_valid_d;
         gain_err_q     <= gain_err_d;
         state_q        <= state_d;
         sr_q           <= sr_d;
         bit_cnt_q      <= bit_cnt_d;
         frame_done_q   <= frame_done_d;
         conv_overrun_q <= conv_overrun_d;
      end
   end
   assign busy         = state_q == SHIFT;
   assign spi_miso     = busy & sr_q[FRAME-1];
   assign amp_dout     = cs_act_q & dshift_q[7];
   assign gain_a       = gain_q[7:4];
   assign gain_b       = gain_q[3:0];
   assign gain_valid   = gain_valid_q;
   assign gain_err     = gain_err_q;
   assign frame_done   = frame_done_q;
   assign conv_overrun = conv_overrun_q;
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed gain-write and ADC-frame checks with hand-computed expectations.
`timescale 1ns/1ps
module tb_adc_spi_responder;
   logic clk = 1'b0, rst_n = 1'b0, spi_sck = 1'b0, spi_mosi = 1'b0, amp_cs = 1'b1, ad_conv = 1'b0;
   logic [13:0] sample_a = '0, sample_b = '0;
   logic spi_miso, amp_dout, gain_valid, gain_err, busy, frame_done, conv_overrun;
   logic [3:0] gain_a, gain_b;
   int n_checks = 0, n_fail = 0;
   int gv_n = 0, ge_n = 0, fd_n = 0, ov_n = 0;
   always #5 clk = ~clk;
   adc_spi_responder dut (
      .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .amp_cs(amp_cs),
      .ad_conv(ad_conv), .sample_a(sample_a), .sample_b(sample_b), .spi_miso(spi_miso),
      .amp_dout(amp_dout), .gain_a(gain_a), .gain_b(gain_b), .gain_valid(gain_valid),
      .gain_err(gain_err), .busy(busy), .frame_done(frame_done), .conv_overrun(conv_overrun)
   );
   always @(negedge clk) begin
      if (gain_valid) gv_n++;
      if (gain_err) ge_n++;
      if (frame_done) fd_n++;
      if (conv_overrun) ov_n++;
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic write_gain(input logic [7:0] val, input int nbits, output logic [7:0] rb);
      rb = '0;
      amp_cs = 1'b0;
      clks(8);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = val[7-i];
         clks(6);
         rb[7-i] = amp_dout;
         spi_sck = 1'b1;
         clks(8);
         spi_sck = 1'b0;
         clks(2);
      end
      clks(6);
      amp_cs = 1'b1;
      clks(8);
   endtask
   task automatic read_bits(input int n, output logic [33:0] bits);
      bits = '0;
      for (int i = 0; i < n; i++) begin
         clks(6);
         bits[33-i] = spi_miso;
         spi_sck = 1'b1;
         clks(8);
         spi_sck = 1'b0;
         clks(2);
      end
   endtask
   task automatic conv_pulse();
      ad_conv = 1'b1;
      clks(4);
      ad_conv = 1'b0;
      clks(2);
   endtask
   initial begin
      int gv0, ge0, fd0, ov0;
      logic [7:0] rb;
      logic [33:0] bits;
      clks(5);
      rst_n = 1'b1;
      clks(8);
      check("rst_gain_a", 64'(gain_a), 64'd1);
      check("rst_gain_b", 64'(gain_b), 64'd1);
      check("rst_miso", 64'(spi_miso), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_no_err", 64'(ge_n), 64'd0);
      gv0 = gv_n;
      write_gain(8'h22, 8, rb);
      check("wr22_valid", 64'(gv_n - gv0), 64'd1);
      check("wr22_gain_a", 64'(gain_a), 64'd2);
      check("wr22_gain_b", 64'(gain_b), 64'd2);
      gv0 = gv_n;
      ge0 = ge_n;
      write_gain(8'hF7, 6, rb);
      check("short_err", 64'(ge_n - ge0), 64'd1);
      check("short_no_valid", 64'(gv_n - gv0), 64'd0);
      check("short_gain_a", 64'(gain_a), 64'd2);
      check("short_gain_b", 64'(gain_b), 64'd2);
      write_gain(8'h35, 8, rb);
      check("wr35_readback", 64'(rb), 64'h22);
      check("wr35_gain_a", 64'(gain_a), 64'd3);
      check("wr35_gain_b", 64'(gain_b), 64'd5);
      check("amp_dout_idle", 64'(amp_dout), 64'd0);
      sample_a = 14'h2ABC;
      sample_b = 14'h1555;
      fd0 = fd_n;
      ov0 = ov_n;
      conv_pulse();
      check("frame_busy", 64'(busy), 64'd1);
      read_bits(34, bits);
      clks(4);
      check("frame_bits", 64'(bits), 64'(34'b00_10101010111100_00_01010101010101_00));
      check("frame_done", 64'(fd_n - fd0), 64'd1);
      check("frame_idle", 64'(busy), 64'd0);
      check("frame_miso0", 64'(spi_miso), 64'd0);
      check("frame_no_ovr", 64'(ov_n - ov0), 64'd0);
      fd0 = fd_n;
      ov0 = ov_n;
      conv_pulse();
      read_bits(10, bits);
      sample_a = 14'h0001;
      conv_pulse();
      check("ovr_pulse", 64'(ov_n - ov0), 64'd1);
      check("ovr_busy", 64'(busy), 64'd1);
      read_bits(34, bits);
      clks(4);
      check("ovr_bits", 64'(bits), 64'(34'b00_00000000000001_00_01010101010101_00));
      check("ovr_done", 64'(fd_n - fd0), 64'd1);
      sample_b = 14'h3FFF;
      conv_pulse();
      read_bits(20, bits);
      clks(6);
      check("bit20_miso", 64'(spi_miso), 64'd1);
      rst_n = 1'b0;
      #1;
      check("arst_miso", 64'(spi_miso), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_gain_a", 64'(gain_a), 64'd1);
      check("arst_gain_b", 64'(gain_b), 64'd1);
      clks(3);
      rst_n = 1'b1;
      clks(8);
      sample_a = 14'h2ABC;
      sample_b = 14'h1555;
      fd0 = fd_n;
      conv_pulse();
      read_bits(34, bits);
      clks(4);
      check("post_rst_bits", 64'(bits), 64'(34'b00_10101010111100_00_01010101010101_00));
      check("post_rst_done", 64'(fd_n - fd0), 64'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
